// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared types and defaults for the execute-stage ALU.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int c_width   = 16;
    localparam int c_shamt_w = 4;

    typedef enum logic [3:0] {
        ALU_AND = 4'h0,
        ALU_OR  = 4'h1,
        ALU_XOR = 4'h2,
        ALU_NOT = 4'h3,
        ALU_NEG = 4'h4,
        ALU_SL  = 4'h5,
        ALU_SR  = 4'h6,
        ALU_ADD = 4'h7,
        ALU_SUB = 4'h8,
        ALU_MUL = 4'h9,
        ALU_NOP = 4'hF
    } alu_ctrl_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_exec_stage_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Purpose  : Unsigned shift-add multiplier, one partial product per cycle.
// Revision : 1.0
// ============================================================================
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int                 c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    logic                 r_busy;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   w_acc_next;

    // done and product are combinational so the caller can register the
    // final accumulation on the same edge as the last iteration.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign done       = r_busy & (r_cnt == c_last);
    assign product    = w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage
// Purpose  : Pipelined execute stage: single-cycle ALU ops plus iterative MUL.
// Revision : 1.0
// ============================================================================
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH   = c_width,
    parameter int SHAMT_W = c_shamt_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        ctrl,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    output logic              illegal
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    state_e              r_state;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_result;
    logic                r_flag_z;
    logic                r_flag_c;
    logic                r_flag_v;
    logic                r_illegal;

    logic                w_accept;
    logic                w_mul_start;
    logic                w_mul_done;
    logic [2*WIDTH-1:0]  w_product;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_diff;
    logic [WIDTH-1:0]    w_res;
    logic                w_c;
    logic                w_v;
    logic                w_ill;
    logic                w_zen;
    logic                w_z;

    // rst_n gates in_ready so nothing is accepted while reset is held.
    assign in_ready    = rst_n & (r_state == IDLE) & (~r_out_valid | out_ready) & ~flush;
    assign w_accept    = in_valid & in_ready;
    assign w_mul_start = w_accept & (ctrl == ALU_MUL);

    assign w_sum  = {1'b0, op_a} + {1'b0, op_b};
    assign w_diff = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_ill = 1'b0;
        w_zen = 1'b1;
        case (ctrl)
            ALU_AND: w_res = op_a & op_b;
            ALU_OR:  w_res = op_a | op_b;
            ALU_XOR: w_res = op_a ^ op_b;
            ALU_NOT: w_res = ~op_a;
            ALU_NEG: w_res = (~op_a) + c_one;
            ALU_SL:  w_res = op_a << op_b[SHAMT_W-1:0];
            ALU_SR:  w_res = op_a >> op_b[SHAMT_W-1:0];
            ALU_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &
                        (w_sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &
                        (w_diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_MUL: w_res = '0;
            // A bubble carries no flags at all, not even zero.
            ALU_NOP: w_zen = 1'b0;
            default: w_ill = 1'b1;
        endcase
        w_z = w_ill | (w_zen & (w_res == '0));
    end

    seq_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .abort   (flush),
        .start   (w_mul_start),
        .a       (op_a),
        .b       (op_b),
        .done    (w_mul_done),
        .product (w_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (ctrl == ALU_MUL) begin
                            r_state     <= MUL;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_flag_z    <= w_z;
                            r_flag_c    <= w_c;
                            r_flag_v    <= w_v;
                            r_illegal   <= w_ill;
                        end
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    if (w_mul_done) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_product[WIDTH-1:0];
                        r_flag_z    <= (w_product[WIDTH-1:0] == '0);
                        r_flag_c    <= 1'b0;
                        r_flag_v    <= |w_product[2*WIDTH-1:WIDTH];
                        r_illegal   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
    assign flag_v    = r_flag_v;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire
